// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX and RX paths: frame constants, default bit
// period and the transmitter state type.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS    = 8;
  localparam int unsigned UART_STOP_BITS    = 1;
  localparam int unsigned UART_CLKS_PER_BIT = 434;  // 50 MHz / 115200

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head entry is visible combinationally
// on pop_data_o so a pop can load it on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: CPU writes land in a FIFO, a bit-timer FSM
// serialises each byte LSB-first with back-to-back frames when data is queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(UART_STOP_BITS - 1);

  tx_state_t       state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            pop;
  logic [7:0]      fifo_head;
  logic            fifo_full, fifo_empty;
  logic            baud_tick;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (wr_valid),
    .push_data_i(wr_data),
    .pop_i      (pop),
    .pop_data_o (fifo_head),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign wr_ready  = !fifo_full;
  assign tx        = tx_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign baud_tick = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_tick) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_tick) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_q[1];  // next bit is already in position 1 before the shift lands
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_tick) begin
          baud_d = '0;
          if (bit_q != STOP_LAST) begin
            bit_d = bit_q + 1'b1;
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            bit_d   = '0;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            bit_d   = '0;
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-schedule reference model predicts the line and
// status outputs every cycle under directed and random write sequences.
module tb_uart_tx_fifo;

  localparam int unsigned C = 4;
  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  uart_tx_fifo #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned passes = 0;

  // Reference model: bytes waiting, and the frame currently on the line as
  // (byte, start edge). A frame is 10*C cycles of start, 8 data bits, stop.
  logic [7:0]  pend[$];
  bit          act = 1'b0;
  logic [7:0]  fbyte = '0;
  int unsigned fstart = 0;
  int unsigned n = 0;
  bit          acc_last = 1'b0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s edge=%0d got=%h exp=%h", tag, n, got, exp);
  endtask

  task automatic model_edge();
    bit acc;
    n++;
    acc_last = 1'b0;
    if (rst) begin
      pend.delete();
      act = 1'b0;
    end else begin
      acc = wr_valid && (pend.size() != D);
      if (act && (n - fstart) == 10 * C) act = 1'b0;
      if (!act && pend.size() != 0) begin
        fbyte  = pend.pop_front();
        fstart = n;
        act    = 1'b1;
      end
      if (acc) pend.push_back(wr_data);
      acc_last = acc;
    end
  endtask

  function automatic logic exp_tx();
    int unsigned idx;
    if (!act) return 1'b1;
    idx = (n - fstart) / C;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return fbyte[idx-1];
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("tx", {7'b0, tx}, {7'b0, exp_tx()});
    chk("busy", {7'b0, busy}, {7'b0, (act || pend.size() != 0)});
    chk("wr_ready", {7'b0, wr_ready}, {7'b0, (pend.size() != D)});
    chk("fifo_count", {5'b0, fifo_count}, 8'(pend.size()));
  endtask

  task automatic write1(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    step();
    wr_valid = 1'b0;
    wr_data  = 8'($urandom);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      step();
      if (!act && pend.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    total++;
    assert (done) passes++;
    else $error("FAIL drain_timeout edge=%0d got=busy exp=idle", n);
    for (int k = 0; k < 3; k++) step();
  endtask

  initial begin
    logic [7:0] b6 [6];
    int unsigned i;
    bit hit;

    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    step();
    step();
    rst = 1'b0;

    // Idle after reset, with wr_data wiggling but no valid.
    for (int k = 0; k < 20; k++) begin
      wr_data = 8'($urandom);
      step();
    end

    // Single byte, then back-to-back pair.
    write1(8'h55);
    drain();
    write1(8'hA5);
    write1(8'h3C);
    drain();

    // Backpressure: hold wr_valid across six random bytes.
    for (int k = 0; k < 6; k++) b6[k] = 8'($urandom);
    i = 0;
    wr_valid = 1'b1;
    wr_data  = b6[0];
    for (int k = 0; k < 400 && i < 6; k++) begin
      step();
      if (acc_last) begin
        i++;
        if (i < 6) wr_data = b6[i];
        else wr_valid = 1'b0;
      end
    end
    wr_valid = 1'b0;
    total++;
    assert (i == 6) passes++;
    else $error("FAIL backpressure_accepts got=%0d exp=6", i);
    drain();

    // Reset during data bit 3 with two bytes queued.
    write1(8'($urandom));
    write1(8'($urandom));
    write1(8'($urandom));
    hit = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (act && (n - fstart) == 4 * C + 1) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    total++;
    assert (hit) passes++;
    else $error("FAIL reach_bit3 edge=%0d got=0 exp=1", n);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 50; k++) step();
    write1(8'hFF);
    drain();

    // Push coinciding with pops: second write meets the IDLE pop, third meets
    // the STOP-to-START pop.
    write1(8'($urandom));
    write1(8'($urandom));
    hit = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (act && (n - fstart) == 10 * C - 1) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    total++;
    assert (hit) passes++;
    else $error("FAIL reach_stop_end edge=%0d got=0 exp=1", n);
    write1(8'($urandom));
    drain();

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      wr_valid = ($urandom_range(0, 5) == 0);
      wr_data  = 8'($urandom);
      step();
    end
    wr_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
